// File: rtl/act_skew_feeder.sv
// Activation skew feeder: streams a run of SRAM words and re-times each lane
// so lane k reaches the systolic array k cycles after lane 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; base/num_rows sampled on acceptance
// READ  | one SRAM read per cycle, num_rows reads total
// DRAIN | no more reads; waiting for the skew chains to empty
// DONE  | one-cycle completion pulse, then back to IDLE
module act_skew_feeder #(
    parameter int ADDRESSSIZE = 10,
    parameter int DATA_BW     = 8,
    parameter int NUM_LANES   = 8,
    parameter int WORDSIZE    = DATA_BW * NUM_LANES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE-1:0] num_rows,
    output logic                   sram_re,
    output logic [ADDRESSSIZE-1:0] sram_addr,
    input  logic [WORDSIZE-1:0]    sram_rdata,
    output logic [WORDSIZE-1:0]    act_out,
    output logic [NUM_LANES-1:0]   act_valid,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   accept;
    logic [ADDRESSSIZE-1:0] addr_q;
    logic [ADDRESSSIZE-1:0] rows_left_q;
    logic                   rd_vld_q;
    logic [NUM_LANES-1:0]   lane_pend;
    logic                   pipe_pending;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        sram_re = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        accept  = 1'b1;
                        state_d = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                sram_re = 1'b1;
                busy    = 1'b1;
                if (rows_left_q == ADDRESSSIZE'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Only the last lane's output stage may still be occupied.
                if (!pipe_pending) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read address and remaining-row down-counter; address holds after the last read
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            rows_left_q <= '0;
        end else if (accept) begin
            addr_q      <= base_addr;
            rows_left_q <= num_rows;
        end else if (state_q == READ) begin
            rows_left_q <= rows_left_q - ADDRESSSIZE'(1);
            if (rows_left_q != ADDRESSSIZE'(1)) begin
                addr_q <= addr_q + ADDRESSSIZE'(1);
            end
        end
    end

    assign sram_addr = addr_q;

    // Valid tag: read data arrives one cycle after the read enable
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= sram_re;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [k:0]         vld_sr;
        logic [DATA_BW-1:0] dat_sr [0:k];

        // Lane k delay chain of k+1 stages; data is zeroed whenever not valid
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_sr <= '0;
                for (int s = 0; s <= k; s++) begin
                    dat_sr[s] <= '0;
                end
            end else begin
                vld_sr[0] <= rd_vld_q;
                dat_sr[0] <= rd_vld_q ? sram_rdata[k*DATA_BW +: DATA_BW] : '0;
                for (int s = 1; s <= k; s++) begin
                    vld_sr[s] <= vld_sr[s-1];
                    dat_sr[s] <= dat_sr[s-1];
                end
            end
        end

        assign act_out[k*DATA_BW +: DATA_BW] = dat_sr[k];
        assign act_valid[k]                  = vld_sr[k];

        if (k == 0) begin : g_head
            assign lane_pend[k] = 1'b0;
        end else begin : g_tail
            assign lane_pend[k] = |vld_sr[k-1:0];
        end
    end

    assign pipe_pending = rd_vld_q | (|lane_pend) | (|act_valid[NUM_LANES-2:0]);

endmodule

// File: tb/tb_act_skew_feeder.sv
// Self-checking bench for act_skew_feeder: directed scenarios plus random
// start/reset traffic, compared every cycle against a timing-formula model.
module tb_act_skew_feeder;

    localparam int AW = 10;
    localparam int BW = 8;
    localparam int NL = 8;
    localparam int WW = BW * NL;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_rows = '0;
    logic          sram_re;
    logic [AW-1:0] sram_addr;
    logic [WW-1:0] sram_rdata = '0;
    logic [WW-1:0] act_out;
    logic [NL-1:0] act_valid;
    logic          busy;
    logic          done;

    logic [WW-1:0] mem [DEPTH];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;

    // model state
    bit      m_active = 1'b0;
    int      m_c0     = 0;
    int      m_base   = 0;
    int      m_rows   = 0;
    int      m_idle   = 0;
    int      m_addr   = 0;

    act_skew_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .sram_re    (sram_re),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .act_out    (act_out),
        .act_valid  (act_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // synchronous-read SRAM, one cycle latency
    always @(posedge clk) begin
        if (sram_re) sram_rdata <= mem[sram_addr];
    end

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    // Expected outputs for the current cycle, then absorb this cycle's inputs.
    task automatic model_cycle();
        logic [WW-1:0] e_act;
        logic [NL-1:0] e_vld;
        logic          e_re, e_busy, e_done;
        int            n, j, dcyc;
        n      = cyc;
        e_act  = '0;
        e_vld  = '0;
        e_re   = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (m_active) begin
            dcyc = (m_rows == 0) ? m_c0 + 1 : m_c0 + m_rows + NL + 2;
            e_done = (n == dcyc);
            if (m_rows > 0) begin
                e_re   = (n >= m_c0 + 1) && (n <= m_c0 + m_rows);
                e_busy = (n >= m_c0 + 1) && (n <= dcyc - 1);
                if (e_re) m_addr = (m_base + (n - m_c0 - 1)) % DEPTH;
                for (int k = 0; k < NL; k++) begin
                    j = n - m_c0 - 3 - k;
                    if (j >= 0 && j < m_rows) begin
                        logic [WW-1:0] w;
                        w = mem[(m_base + j) % DEPTH];
                        e_vld[k] = 1'b1;
                        e_act[k*BW +: BW] = w[k*BW +: BW];
                    end
                end
            end
        end
        if (chk_on) begin
            chk("sram_re",   WW'(sram_re),   WW'(e_re));
            chk("sram_addr", WW'(sram_addr), WW'(m_addr));
            chk("act_out",   act_out,        e_act);
            chk("act_valid", WW'(act_valid), WW'(e_vld));
            chk("busy",      WW'(busy),      WW'(e_busy));
            chk("done",      WW'(done),      WW'(e_done));
        end
        if (rst) begin
            m_active = 1'b0;
            m_addr   = 0;
            m_idle   = n + 1;
        end else if (start && n >= m_idle) begin
            m_active = 1'b1;
            m_c0     = n;
            m_base   = int'(base_addr);
            m_rows   = int'(num_rows);
            m_idle   = (m_rows == 0) ? n + 2 : n + m_rows + NL + 3;
        end
    endtask

    task automatic step(input logic st, input int b, input int nr, input logic rs);
        start     = st;
        base_addr = AW'(b);
        num_rows  = AW'(nr);
        rst       = rs;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        chk_on = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'h0807060504030201;
        mem[4] = 64'h1111111111111111;
        mem[5] = 64'h2222222222222222;
        mem[6] = 64'h3333333333333333;
        mem[7] = 64'h4444444444444444;

        #1;
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        idle(2);

        // single row
        step(1'b1, 0, 1, 1'b0);
        idle(14);

        // four rows, then back-to-back start at relative cycle 15
        step(1'b1, 4, 4, 1'b0);
        idle(14);
        step(1'b1, 4, 4, 1'b0);
        idle(16);

        // zero rows
        step(1'b1, 9, 0, 1'b0);
        idle(4);

        // address wrap with ignored starts at cycles 3 and 14
        step(1'b1, 1022, 4, 1'b0);
        idle(2);
        step(1'b1, 100, 3, 1'b0);
        idle(10);
        step(1'b1, 200, 2, 1'b0);
        idle(4);

        // reset mid-stream, then a clean run from a new base
        step(1'b1, 50, 8, 1'b0);
        idle(5);
        step(1'b0, 0, 0, 1'b1);
        idle(3);
        step(1'b1, 300, 3, 1'b0);
        idle(15);

        // maximum row count, wrapping the address space
        step(1'b1, 1000, DEPTH - 1, 1'b0);
        idle(DEPTH + 12);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            logic st, rs;
            int   nr;
            st = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 150) == 0);
            nr = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 14);
            step(st, $urandom_range(0, DEPTH - 1), nr, rs);
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
